// File: rtl/alu_drv_pkg.sv
// Shared types and constants for the ALU tile front-end: FSM states,
// pin widths, the captured-response record and the settle-timer load helper.
package alu_drv_pkg;

    localparam int OP_W  = 4;
    localparam int SEL_W = 3;
    localparam int RES_W = 8;
    localparam int TMR_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic [RES_W-1:0] y;
        logic             zero;
        logic             carry;
        logic [SEL_W-1:0] sel;
    } rsp_t;

    // Keeps an out-of-range settle parameter inside what the 4-bit timer can hold.
    function automatic logic [TMR_W-1:0] settle_load(input int cycles);
        logic [TMR_W-1:0] val;
        if (cycles < 1) begin
            val = 4'd1;
        end else if (cycles > 15) begin
            val = 4'd15;
        end else begin
            val = TMR_W'(cycles);
        end
        return val;
    endfunction

endpackage

// File: rtl/alu_drv_timer.sv
// Settle timer: 4-bit loadable down-counter; expire marks the final hold cycle
// so the owner can sample on that same edge.
module alu_drv_timer
    import alu_drv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Next count: load wins, otherwise count down while enabled and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == 4'd1);

endmodule

// File: rtl/alu_drv.sv
// Host-side driver for the 4-bit ALU tile: accepts one command, holds the
// operand pins for SETTLE_CYCLES edges, samples the result and returns it.
module alu_drv
    import alu_drv_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_a,
    input  logic [OP_W-1:0]  cmd_b,
    input  logic [SEL_W-1:0] cmd_sel,
    output logic [OP_W-1:0]  alu_a,
    output logic [OP_W-1:0]  alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [RES_W-1:0] alu_y,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RES_W-1:0] rsp_y,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic [SEL_W-1:0] rsp_sel,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [TMR_W-1:0] SETTLE_LD = settle_load(SETTLE_CYCLES);

    state_e           state_q;
    rsp_t             rsp_q;
    logic             rsp_valid_q;
    logic [OP_W-1:0]  alu_a_q;
    logic [OP_W-1:0]  alu_b_q;
    logic [SEL_W-1:0] alu_sel_q;
    logic [CNT_W-1:0] op_count_q;
    logic [CNT_W-1:0] op_count_d;

    logic cmd_fire_s;
    logic rsp_fire_s;
    logic tmr_en_s;
    logic tmr_expire_s;

    assign cmd_fire_s = cmd_valid && (state_q == IDLE);
    assign rsp_fire_s = rsp_valid_q && rsp_ready;
    assign tmr_en_s   = (state_q == SETTLE);
    assign op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};

    alu_drv_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cmd_fire_s),
        .load_val_i (SETTLE_LD),
        .en_i       (tmr_en_s),
        .expire_o   (tmr_expire_s)
    );

    // Control FSM plus operand, response and completion-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            alu_a_q     <= 4'd0;
            alu_b_q     <= 4'd0;
            alu_sel_q   <= 3'd0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_fire_s) begin
                        alu_a_q   <= cmd_a;
                        alu_b_q   <= cmd_b;
                        alu_sel_q <= cmd_sel;
                        rsp_q.sel <= cmd_sel;
                        state_q   <= SETTLE;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                SETTLE: begin
                    // Sampling edge: ALU pins have been stable for SETTLE_CYCLES edges.
                    if (tmr_expire_s) begin
                        rsp_q.y     <= alu_y;
                        rsp_q.zero  <= alu_zero;
                        rsp_q.carry <= alu_carry;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        state_q     <= SETTLE;
                    end
                end
                RESP: begin
                    if (rsp_fire_s) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_d;
                        state_q     <= IDLE;
                    end else begin
                        state_q     <= RESP;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_q.y;
    assign rsp_zero  = rsp_q.zero;
    assign rsp_carry = rsp_q.carry;
    assign rsp_sel   = rsp_q.sel;
    assign op_count  = op_count_q;

endmodule

// File: doc/alu_drv.md
# alu_drv

Synchronous front-end that drives the 4-bit ALU tile from the host side. It accepts one ALU command (A, B, sel) over a valid/ready handshake and drives the operand/selector pins. It holds them for a programmable settle time, then samples the 8-bit result plus zero/carry flags. The captured response is returned over a second valid/ready handshake. It sits between a host controller (or test sequencer) and the ALU's ui_in/uio_in/uo_out/uio_out pins.

## Interface

Parameters:
- SETTLE_CYCLES, default 2: clock edges operands are held before sampling; legal range 1..15.
- CNT_W, default 16: width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_a  in  4  operand A.
- cmd_b  in  4  operand B.
- cmd_sel  in  3  ALU operation select.
- alu_a  out  4  to ALU ui_in[3:0].
- alu_b  out  4  to ALU ui_in[7:4].
- alu_sel  out  3  to ALU uio_in[2:0].
- alu_y  in  8  from ALU uo_out.
- alu_zero  in  1  from ALU uio_out[0].
- alu_carry  in  1  from ALU uio_out[1].
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_y  out  8  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_carry  out  1  captured carry flag.
- rsp_sel  out  3  echo of the command's sel.
- busy  out  1  high in any state other than IDLE.
- op_count  out  CNT_W  completed responses; wraps from all-ones to 0.

## Operation

- States: IDLE, SETTLE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: register cmd_a/b/sel into alu_a/b/sel and rsp_sel, load timer=SETTLE_CYCLES, go to SETTLE.
- SETTLE:
  - cmd_ready=0.
  - Decrement the timer each edge.
  - On the edge where timer==1: capture alu_y/zero/carry into rsp_*, set rsp_valid, go to RESP.
- RESP:
  - rsp_valid=1; rsp_* held stable.
  - On rsp_valid&&rsp_ready: clear rsp_valid, increment op_count, go to IDLE.
- cmd_ready is asserted only in IDLE. There is no command buffering and no overlap of operations.
- alu_a/b/sel keep the last command's values after completion; they change only on a new accept or on reset.
- rsp_y/zero/carry/sel keep their last captured values after the handshake.
- ALU input changes outside the sampling edge never affect rsp_*.
- Reset mid-operation:
  - state→IDLE, rsp_valid→0, op_count→0, alu_* and rsp_*→0.
  - The in-flight operation is discarded and no response is produced.
- rst has priority over every handshake in the same cycle.

## Timing

- Reset values: cmd_ready=1, busy=0, rsp_valid=0, alu_a=alu_b=0, alu_sel=0, rsp_y=0, rsp_zero=0, rsp_carry=0, rsp_sel=0, op_count=0.
- Let E0 be the accept edge:
  - alu_* are valid from just after E0.
  - Sampling occurs at edge E0+SETTLE_CYCLES.
  - rsp_valid rises just after that same edge.
- Latency from accept to rsp_valid is SETTLE_CYCLES edges.
- With rsp_ready held high: the response handshake is at E0+SETTLE_CYCLES+1, IDLE follows, and the next accept is at E0+SETTLE_CYCLES+2.
  - Peak throughput is one op per SETTLE_CYCLES+2 cycles.
- rsp_ready low stalls in RESP indefinitely; nothing is lost or overwritten.
- busy is a registered-state decode, i.e. busy = (state != IDLE).

## Structure

- Package alu_drv_pkg:
  - state enum {IDLE, SETTLE, RESP}.
  - Constants OP_W=4, SEL_W=3, RES_W=8.
  - Response struct {y, zero, carry, sel}.
- One sub-module, alu_drv_timer:
  - 4-bit loadable down-counter with a load input and an expire output (expire = count==1).
- FSM, operand registers, response registers and op_count live in alu_drv.

## Test plan

- Reset, then idle with cmd_valid=0:
  - cmd_ready=1, busy=0, rsp_valid=0, all alu_*/rsp_*/op_count = 0.
- SETTLE_CYCLES=2; accept cmd_a=4'h9, cmd_b=4'h7, sel=3'd0; bench ALU model returns y=8'h10, carry=1, zero=0 from the edge after accept:
  - rsp_valid high 2 edges after accept.
  - rsp_y=8'h10, rsp_carry=1, rsp_zero=0, rsp_sel=0.
  - op_count=1 after the handshake.
- Backpressure: hold rsp_ready=0 for 10 cycles, change alu_y to 8'hFF after sampling, assert cmd_valid throughout:
  - rsp_y stays 8'h10, cmd_ready stays 0.
  - Second command is accepted only one cycle after the rsp handshake.
- Back-to-back with rsp_ready=1 and cmd_valid=1:
  - Accepts exactly every 4 cycles (SETTLE_CYCLES=2).
  - 4 ops → op_count=4; alu_a/b track each command.
- Assert rst one cycle after accept (in SETTLE):
  - No rsp_valid ever appears for that command, op_count=0, cmd_ready=1 the cycle after reset.
- op_count preloaded to 16'hFFFF via 65535 ops (or a forced value) plus one more handshake:
  - op_count=16'h0000.
  - Repeat with SETTLE_CYCLES=1: rsp_valid is 1 edge after accept.
